// File: rtl/instr_fetch_seq.sv
// Instruction fetch/sequencer feeding simple_cpu.
// Holds a small writable program memory. Each word is presented on 'instruction'
// for a class-dependent number of cycles, then the next word follows with no bubble.
module instr_fetch_seq #(
   parameter int unsigned INSTR_WIDTH    = 20,
   parameter int unsigned PROG_ADDR_BITS = 4,
   parameter int unsigned HOLD_ALU       = 4,
   parameter int unsigned HOLD_MEM       = 3,
   parameter int unsigned HOLD_NOP       = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      prog_we,
   input  logic [PROG_ADDR_BITS-1:0] prog_addr,
   input  logic [INSTR_WIDTH-1:0]    prog_data,
   input  logic [PROG_ADDR_BITS:0]   prog_len,
   input  logic                      start,
   output logic [INSTR_WIDTH-1:0]    instruction,
   output logic                      instr_valid,
   output logic [PROG_ADDR_BITS-1:0] pc,
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned DEPTH = 1 << PROG_ADDR_BITS;
   localparam int unsigned LEN_W = PROG_ADDR_BITS + 1;

   // A hold of zero cycles is meaningless; clamp to one.
   localparam int unsigned H_ALU = (HOLD_ALU == 0) ? 1 : HOLD_ALU;
   localparam int unsigned H_MEM = (HOLD_MEM == 0) ? 1 : HOLD_MEM;
   localparam int unsigned H_NOP = (HOLD_NOP == 0) ? 1 : HOLD_NOP;
   localparam int unsigned H_AM  = (H_ALU > H_MEM) ? H_ALU : H_MEM;
   localparam int unsigned H_MAX = (H_AM > H_NOP) ? H_AM : H_NOP;
   localparam int unsigned CNT_W = (H_MAX > 1) ? $clog2(H_MAX) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                    state_q, state_d;
   logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [LEN_W-1:0]          len_q, len_d;
   logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
   logic                      valid_q, valid_d;

   logic [INSTR_WIDTH-1:0]    mem [DEPTH];
   logic                      mem_we;
   logic [INSTR_WIDTH-1:0]    word0;
   logic [PROG_ADDR_BITS-1:0] pc_inc;
   logic [INSTR_WIDTH-1:0]    word_next;
   logic [LEN_W-1:0]          len_sat;
   logic                      last;

   // Remaining hold cycles after the first, from the class bits of a word.
   function automatic logic [CNT_W-1:0] hold_m1(input logic [INSTR_WIDTH-1:0] w);
      logic [CNT_W-1:0] h;
      case (w[INSTR_WIDTH-1 -: 2])
         2'b00:   h = CNT_W'(H_NOP - 1);
         2'b01:   h = CNT_W'(H_ALU - 1);
         default: h = CNT_W'(H_MEM - 1);
      endcase
      return h;
   endfunction

   assign mem_we    = prog_we && (state_q != StRun);
   // A same-cycle write to address 0 must be what a start issues.
   assign word0     = (mem_we && (prog_addr == '0)) ? prog_data : mem[0];
   assign pc_inc    = pc_q + 1'b1;
   assign word_next = mem[pc_inc];
   assign len_sat   = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
   assign last      = ({1'b0, pc_q} == (len_q - 1'b1));

   // Program memory: no reset, so contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[prog_addr] <= prog_data;
      end
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      instr_d = instr_q;
      valid_d = valid_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               len_d = len_sat;
               if (len_sat == '0) begin
                  state_d = StDone;
                  instr_d = '0;
                  valid_d = 1'b0;
               end else begin
                  state_d = StRun;
                  pc_d    = '0;
                  instr_d = word0;
                  valid_d = 1'b1;
                  cnt_d   = hold_m1(word0);
               end
            end
         end
         StRun: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (last) begin
               // pc stays on the final address; pc+1 is never used here.
               state_d = StDone;
               instr_d = '0;
               valid_d = 1'b0;
               cnt_d   = '0;
            end else begin
               pc_d    = pc_inc;
               instr_d = word_next;
               cnt_d   = hold_m1(word_next);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pc_q    <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign busy        = (state_q == StRun);
   assign done        = (state_q == StDone);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq with hand-computed expected sequences.
module tb_instr_fetch_seq;

   logic        clk;
   logic        rst;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [19:0] prog_data;
   logic [4:0]  prog_len;
   logic        start;
   logic [19:0] instruction;
   logic        instr_valid;
   logic [3:0]  pc;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [19:0] prog6 [6] = '{20'h47000, 20'h53000, 20'h72001, 20'hD80F0, 20'hCC160, 20'hB80F0};
   int          hold6 [6] = '{4, 4, 4, 3, 3, 3};

   instr_fetch_seq dut (
      .clk         (clk),
      .rst         (rst),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_len    (prog_len),
      .start       (start),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .pc          (pc),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [3:0] a, input logic [19:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic pulse_start(input logic [4:0] len);
      prog_len = len;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_instr"}, 32'(instruction), 32'h0);
      check({tag, "_valid"}, 32'(instr_valid), 32'h0);
      check({tag, "_pc"}, 32'(pc), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_done"}, 32'(done), 32'h0);
   endtask

   task automatic check_done(input string tag, input logic [3:0] last_pc);
      check({tag, "_done"}, 32'(done), 32'h1);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_valid"}, 32'(instr_valid), 32'h0);
      check({tag, "_instr"}, 32'(instruction), 32'h0);
      check({tag, "_pc"}, 32'(pc), 32'(last_pc));
   endtask

   // Called just after the start edge; optionally writes mem[1] while word 0 is held.
   task automatic check_run6(input string tag, input bit write_in_run);
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < hold6[k]; j++) begin
            check($sformatf("%s_w%0d_c%0d_instr", tag, k, j), 32'(instruction), 32'(prog6[k]));
            check($sformatf("%s_w%0d_c%0d_pc", tag, k, j), 32'(pc), 32'(k));
            check($sformatf("%s_w%0d_c%0d_busy", tag, k, j), 32'(busy & instr_valid), 32'h1);
            if (write_in_run && k == 0 && j == 0) begin
               prog_we   = 1'b1;
               prog_addr = 4'd1;
               prog_data = 20'h00000;
            end
            tick();
            prog_we = 1'b0;
         end
      end
      check_done({tag, "_end"}, 4'd5);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b1;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      prog_len  = 5'd6;

      // Reset wins over start.
      tick();
      check_idle_outputs("rst0");
      tick();
      check_idle_outputs("rst1");
      rst   = 1'b0;
      start = 1'b0;

      for (int i = 0; i < 6; i++) write_word(4'(i), prog6[i]);
      check_idle_outputs("load");

      // Zero length goes straight to DONE without ever issuing.
      pulse_start(5'd0);
      check_done("zlen", 4'd0);
      tick();
      check_done("zlen_hold", 4'd0);

      // Main program, restarted from DONE, with a write attempt during RUN.
      pulse_start(5'd6);
      check_run6("run", 1'b1);
      tick();
      check_done("run_stay", 4'd5);

      // Reset during the second hold cycle of word 2.
      pulse_start(5'd6);
      repeat (9) tick();
      check("mid_word2", 32'(instruction), 32'h72001);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_outputs("midrst");
      pulse_start(5'd6);
      check_run6("replay", 1'b0);

      // Full 16-entry program of single-cycle words, then saturated length.
      for (int i = 0; i < 16; i++) write_word(4'(i), 20'h00100 + 20'(i));
      for (int r = 0; r < 2; r++) begin
         pulse_start((r == 0) ? 5'd16 : 5'd31);
         for (int i = 0; i < 16; i++) begin
            check($sformatf("full%0d_%0d_instr", r, i), 32'(instruction), 32'h100 + 32'(i));
            check($sformatf("full%0d_%0d_pc", r, i), 32'(pc), 32'(i));
            tick();
         end
         check_done($sformatf("full%0d_end", r), 4'd15);
      end

      // Write to address 0 in the same cycle as start issues the new word.
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = 20'h00ABC;
      pulse_start(5'd1);
      prog_we = 1'b0;
      check("fwd_instr", 32'(instruction), 32'h00ABC);
      check("fwd_valid", 32'(instr_valid), 32'h1);
      tick();
      check_done("fwd_end", 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
